// File: rtl/uart_pkg.sv
// Shared UART definitions: shifter state encoding, frame geometry and default baud divisor.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and occupancy; shared by the UART TX and RX paths.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [LW-1:0]    w_level_nxt;

  // Flags gate both sides, so level can never wrap in either direction.
  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push_ok && !w_pop_ok) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == LW'(0));
    end
  end

  // Storage carries no reset; pointer reset alone discards contents.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit path: byte FIFO feeding an 8N1 shifter with a fixed baud divisor.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH   = 16,
  parameter  int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  localparam int unsigned LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tx_push,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      ovf_clr,
  output logic                      tx_fifo_full,
  output logic                      tx_fifo_empty,
  output logic [LW-1:0]             tx_level,
  output logic                      tx_busy,
  output logic                      tx_overflow,
  output logic                      uart_txd
);

  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] BIT_LAST = BIW'(UART_DATA_BITS - 1);

  uart_tx_state_t            r_state;
  uart_tx_state_t            w_state_nxt;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             w_cnt_nxt;
  logic [BIW-1:0]            r_idx;
  logic [BIW-1:0]            w_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      r_txd;
  logic                      w_txd_nxt;
  logic                      r_busy;
  logic                      r_ovf;
  logic                      w_pop;
  logic                      w_tick;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [UART_DATA_BITS-1:0] w_fifo_dout;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (tx_push),
    .i_din   (tx_data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (tx_level)
  );

  assign w_tick = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_txd_nxt   = 1'b1;
    if (r_state != ST_IDLE) begin
      w_cnt_nxt = w_tick ? '0 : r_cnt + CW'(1);
    end
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_idx_nxt   = '0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == BIT_LAST) w_state_nxt = ST_STOP;
          else                   w_idx_nxt   = r_idx + BIW'(1);
        end
      end
      ST_STOP: begin
        // Reload straight into START so queued frames go out gapless.
        if (w_tick) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dout;
            w_idx_nxt   = '0;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    case (w_state_nxt)
      ST_START: w_txd_nxt = 1'b0;
      ST_DATA:  w_txd_nxt = w_shift_nxt[0];
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      // A dropped push beats a coincident clear.
      if (tx_push && w_fifo_full) r_ovf <= 1'b1;
      else if (ovf_clr)           r_ovf <= 1'b0;
    end
  end

  assign tx_fifo_full  = w_fifo_full;
  assign tx_fifo_empty = w_fifo_empty;
  assign tx_busy       = r_busy;
  assign tx_overflow   = r_ovf;
  assign uart_txd      = r_txd;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_serializer;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tx_push;
  logic [7:0]    tx_data;
  logic          ovf_clr;
  logic          tx_fifo_full;
  logic          tx_fifo_empty;
  logic [LW-1:0] tx_level;
  logic          tx_busy;
  logic          tx_overflow;
  logic          uart_txd;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_serializer #(
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_push       (tx_push),
    .tx_data       (tx_data),
    .ovf_clr       (ovf_clr),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_level      (tx_level),
    .tx_busy       (tx_busy),
    .tx_overflow   (tx_overflow),
    .uart_txd      (uart_txd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offset k counts edges since the START edge; checks offsets k0..k1-1, ends at offset k1.
  task automatic check_frame(input logic [7:0] b, input int k0, input int k1);
    logic exp;
    for (int k = k0; k < k1; k++) begin
      if (k < 4 * CPB / 4 * 1 && k < int'(CPB)) exp = 1'b0;
      else if (k < int'(9 * CPB)) exp = b[(k - int'(CPB)) / int'(CPB)];
      else exp = 1'b1;
      chk($sformatf("txd_%02h_k%0d", b, k), 32'(uart_txd), 32'(exp));
      chk($sformatf("busy_%02h_k%0d", b, k), 32'(tx_busy), 32'd1);
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    tx_push = 1'b0;
    tx_data = 8'h00;
    ovf_clr = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_txd",   32'(uart_txd),      32'd1);
    chk("rst_full",  32'(tx_fifo_full),  32'd0);
    chk("rst_empty", 32'(tx_fifo_empty), 32'd1);
    chk("rst_level", 32'(tx_level),      32'd0);
    chk("rst_busy",  32'(tx_busy),       32'd0);
    chk("rst_ovf",   32'(tx_overflow),   32'd0);
    rst_n = 1'b1;
    step();

    // Single byte 0x55
    tx_push = 1'b1; tx_data = 8'h55;
    step();                                   // E0
    tx_push = 1'b0;
    chk("s_e0_level", 32'(tx_level),      32'd1);
    chk("s_e0_empty", 32'(tx_fifo_empty), 32'd0);
    chk("s_e0_txd",   32'(uart_txd),      32'd1);
    chk("s_e0_busy",  32'(tx_busy),       32'd0);
    step();                                   // E1
    chk("s_e1_empty", 32'(tx_fifo_empty), 32'd1);
    chk("s_e1_level", 32'(tx_level),      32'd0);
    check_frame(8'h55, 0, 40);                // now at E41
    chk("s_e41_busy", 32'(tx_busy),  32'd0);
    chk("s_e41_txd",  32'(uart_txd), 32'd1);

    // Burst 0x41..0x46 with overflow on the sixth push
    tx_push = 1'b1; tx_data = 8'h41;
    step();                                   // E0
    tx_data = 8'h42;
    chk("b_e0_level", 32'(tx_level), 32'd1);
    step();                                   // E1
    tx_data = 8'h43;
    chk("b_e1_level", 32'(tx_level), 32'd1);
    chk("b_e1_txd",   32'(uart_txd), 32'd0);
    step();                                   // E2
    tx_data = 8'h44;
    chk("b_e2_level", 32'(tx_level), 32'd2);
    step();                                   // E3
    tx_data = 8'h45;
    chk("b_e3_level", 32'(tx_level), 32'd3);
    step();                                   // E4
    tx_data = 8'h46;
    chk("b_e4_level", 32'(tx_level),     32'd4);
    chk("b_e4_full",  32'(tx_fifo_full), 32'd1);
    chk("b_e4_ovf",   32'(tx_overflow),  32'd0);
    step();                                   // E5
    tx_push = 1'b0;
    chk("b_e5_level", 32'(tx_level),    32'd4);
    chk("b_e5_ovf",   32'(tx_overflow), 32'd1);
    check_frame(8'h41, 4, 40);
    check_frame(8'h42, 0, 40);
    check_frame(8'h43, 0, 40);
    check_frame(8'h44, 0, 40);
    check_frame(8'h45, 0, 40);                // now at E201
    chk("b_end_busy",  32'(tx_busy),       32'd0);
    chk("b_end_empty", 32'(tx_fifo_empty), 32'd1);
    chk("b_end_level", 32'(tx_level),      32'd0);
    chk("b_end_txd",   32'(uart_txd),      32'd1);

    // Overflow clear pulse alone
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_alone", 32'(tx_overflow), 32'd0);

    // Fill, coincident clear with dropped push, then push on final STOP tick
    tx_push = 1'b1; tx_data = 8'h10;
    step();                                   // E0
    tx_data = 8'h20;
    step();                                   // E1
    tx_data = 8'h30;
    step();                                   // E2
    tx_data = 8'h40;
    step();                                   // E3
    tx_data = 8'h50;
    step();                                   // E4
    tx_data = 8'h60; ovf_clr = 1'b1;
    chk("f_e4_level", 32'(tx_level),     32'd4);
    chk("f_e4_full",  32'(tx_fifo_full), 32'd1);
    chk("f_e4_ovf",   32'(tx_overflow),  32'd0);
    step();                                   // E5
    tx_push = 1'b0;
    chk("f_set_wins", 32'(tx_overflow), 32'd1);
    chk("f_e5_level", 32'(tx_level),    32'd4);
    step();                                   // E6
    ovf_clr = 1'b0;
    chk("f_clr", 32'(tx_overflow), 32'd0);
    check_frame(8'h10, 5, 39);                // now at E40
    tx_push = 1'b1; tx_data = 8'h70;
    chk("f_e40_txd",   32'(uart_txd),     32'd1);
    chk("f_e40_level", 32'(tx_level),     32'd4);
    step();                                   // E41
    tx_push = 1'b0;
    chk("pp_level", 32'(tx_level),     32'd3);
    chk("pp_full",  32'(tx_fifo_full), 32'd0);
    chk("pp_ovf",   32'(tx_overflow),  32'd1);
    check_frame(8'h20, 0, 40);
    do_reset();

    // Reset during DATA bit 3 of 0xA5 with two bytes queued
    tx_push = 1'b1; tx_data = 8'hA5;
    step();                                   // E0
    tx_data = 8'hB1;
    step();                                   // E1
    tx_data = 8'hB2;
    step();                                   // E2
    tx_push = 1'b0;
    chk("r_e2_level", 32'(tx_level), 32'd2);
    check_frame(8'hA5, 1, 18);                // offset 18, inside bit 3
    chk("r_bit3_txd", 32'(uart_txd), 32'd0);
    rst_n = 1'b0;
    step();
    chk("r_txd",   32'(uart_txd),      32'd1);
    chk("r_level", 32'(tx_level),      32'd0);
    chk("r_busy",  32'(tx_busy),       32'd0);
    chk("r_empty", 32'(tx_fifo_empty), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk($sformatf("r_quiet_txd_%0d", i),  32'(uart_txd), 32'd1);
      chk($sformatf("r_quiet_busy_%0d", i), 32'(tx_busy),  32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
